magic_ctl: RTL and testbench

Parametrised magic-ROM controller; next generation of the single-button magic block. Arbitrates NTRIG NMI trigger sources and records which one fired. Sequences magic-ROM map/unmap around the Z80 NMI entry point and verifies the ROM signature. Exposes a generic, readable bank of NCFG 8-bit configuration registers on a single I/O port while the magic ROM is mapped.

---
 rtl/magic_ctl.sv | 241 ++++++++++++++++++++++++
 tb/tb_magic_ctl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/magic_ctl.sv
// magic_ctl: magic-ROM controller. Arbitrates NMI trigger sources, sequences
// magic-ROM map/unmap around the Z80 NMI entry point, verifies the ROM
// signature, and exposes a bank of 8-bit config registers on one I/O port
// while the ROM is mapped.

// One config register with its write strobe.
module magic_cfg_reg #(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       we,
    input  logic [7:0] wdata,
    output logic [7:0] q,
    output logic       wstb
);

    // Load on write; the strobe is the registered write enable so it lines
    // up with the register update.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            q    <= RST_VAL;
            wstb <= 1'b0;
        end else begin
            wstb <= we;
            if (we) q <= wdata;
        end
    end

endmodule

module magic_ctl #(
    parameter int                NTRIG        = 2,
    parameter int                NCFG         = 12,
    parameter logic [7:0]        CFG_PORT     = 8'hFF,
    parameter logic [15:0]       ENTRY_ADDR   = 16'h0066,
    parameter logic [15:0]       EXIT_ADDR    = 16'hF000,
    parameter logic [15:0]       REENTER_ADDR = 16'hF008,
    parameter logic [7:0]        SIGNATURE    = 8'hEB,
    parameter logic [NCFG*8-1:0] CFG_RESET    = '0
) (
    input  logic              clk28,
    input  logic              rst_n,
    input  logic              mreq,
    input  logic              ioreq,
    input  logic              m1,
    input  logic              rd,
    input  logic              wr,
    input  logic [15:0]       a,
    input  logic [7:0]        d,
    input  logic              n_int,
    input  logic              n_int_next,
    input  logic [NTRIG-1:0]  trig,
    output logic              n_nmi,
    output logic              magic_mode,
    output logic              magic_map,
    output logic [2:0]        cause,
    output logic [NCFG*8-1:0] cfg,
    output logic [NCFG-1:0]   cfg_wstb,
    output logic              rd_oe,
    output logic [7:0]        rd_data
);

    typedef enum logic [2:0] {
        BOOT_CHECK,
        IDLE,
        PENDING,
        CHECK,
        MAPPED,
        UNMAP_WAIT,
        REENTER
    } state_t;

    state_t state;
    logic   sig_seen;   // an opcode fetch has been observed in this check
    logic   sig_ok;     // last sampled opcode matched the signature
    logic   reenter;    // UNMAP_WAIT should go to REENTER rather than IDLE

    logic       int_edge;
    logic       fetch;
    logic [2:0] trig_idx;
    logic       trig_any;

    assign int_edge = n_int & ~n_int_next;
    assign fetch    = m1 & mreq & rd;
    assign trig_any = |trig;

    // Lowest set trigger index wins.
    always_comb begin
        trig_idx = 3'd0;
        for (int i = NTRIG - 1; i >= 0; i--) begin
            if (trig[i]) trig_idx = 3'(i);
        end
    end

    // Session sequencer: NMI request, ROM map/unmap and signature checks.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            state      <= BOOT_CHECK;
            n_nmi      <= 1'b1;
            magic_mode <= 1'b1;
            magic_map  <= 1'b1;
            cause      <= 3'd0;
            sig_seen   <= 1'b0;
            sig_ok     <= 1'b0;
            reenter    <= 1'b0;
        end else begin
            case (state)
                BOOT_CHECK, CHECK: begin
                    // Keep sampling while the fetch is held; decide once it ends.
                    if (fetch) begin
                        sig_seen <= 1'b1;
                        sig_ok   <= (d == SIGNATURE);
                    end else if (sig_seen) begin
                        sig_seen <= 1'b0;
                        if (sig_ok) begin
                            state <= MAPPED;
                        end else begin
                            state      <= IDLE;
                            magic_mode <= 1'b0;
                            magic_map  <= 1'b0;
                        end
                    end
                end
                IDLE: begin
                    if (int_edge && trig_any) begin
                        cause      <= trig_idx;
                        n_nmi      <= 1'b0;
                        magic_mode <= 1'b1;
                        state      <= PENDING;
                    end
                end
                PENDING: begin
                    if (m1 && mreq && a == ENTRY_ADDR) begin
                        n_nmi     <= 1'b1;
                        magic_map <= 1'b1;
                        state     <= CHECK;
                        // The entry fetch itself carries the opcode to check.
                        sig_seen  <= fetch;
                        sig_ok    <= (d == SIGNATURE);
                    end
                end
                MAPPED: begin
                    if (mreq && rd && a == EXIT_ADDR) begin
                        magic_mode <= 1'b0;
                        reenter    <= 1'b0;
                        state      <= UNMAP_WAIT;
                    end else if (mreq && rd && a == REENTER_ADDR) begin
                        reenter <= 1'b1;
                        state   <= UNMAP_WAIT;
                    end
                end
                UNMAP_WAIT: begin
                    // ROM stays mapped until the exit read has completed.
                    if (!mreq) begin
                        magic_map <= 1'b0;
                        state     <= reenter ? REENTER : IDLE;
                    end
                end
                REENTER: begin
                    if (m1 && mreq) begin
                        magic_map <= 1'b1;
                        state     <= MAPPED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Config port decode.
    logic       cs;
    logic [7:0] idx;
    logic       cs_wr_q;
    logic       wr_rise;

    assign cs      = magic_map & ioreq & (a[7:0] == CFG_PORT);
    assign idx     = a[15:8];
    assign wr_rise = cs & wr & ~cs_wr_q;

    // Remember cs&wr so each I/O write cycle produces a single strobe.
    always_ff @(posedge clk28) begin
        if (!rst_n) cs_wr_q <= 1'b0;
        else        cs_wr_q <= cs & wr;
    end

    logic [NCFG-1:0][7:0] cfg_q;
    logic [NCFG-1:0]      cfg_we;

    for (genvar i = 0; i < NCFG; i++) begin : g_cfg
        assign cfg_we[i] = wr_rise && (idx == 8'(i));
        magic_cfg_reg #(
            .RST_VAL (CFG_RESET[8*i +: 8])
        ) u_reg (
            .clk28 (clk28),
            .rst_n (rst_n),
            .we    (cfg_we[i]),
            .wdata (d),
            .q     (cfg_q[i]),
            .wstb  (cfg_wstb[i])
        );
    end

    assign cfg = cfg_q;

    // Readback selection for the addressed register.
    logic       rd_hit;
    logic [7:0] rd_sel;

    always_comb begin
        rd_hit = 1'b0;
        rd_sel = 8'h00;
        for (int i = 0; i < NCFG; i++) begin
            if (idx == 8'(i)) begin
                rd_hit = 1'b1;
                rd_sel = cfg_q[i];
            end
        end
    end

    // Registered readback: register contents, or status at index 8'hFF.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            rd_oe   <= 1'b0;
            rd_data <= 8'h00;
        end else begin
            rd_oe   <= 1'b0;
            rd_data <= 8'h00;
            if (cs && rd) begin
                if (rd_hit) begin
                    rd_oe   <= 1'b1;
                    rd_data <= rd_sel;
                end else if (idx == 8'hFF) begin
                    rd_oe   <= 1'b1;
                    rd_data <= {magic_mode, 4'b0000, cause};
                end
            end
        end
    end

endmodule

// File: tb/tb_magic_ctl.sv
// tb_magic_ctl: directed and randomized bus transactions against a
// transaction-level model of the magic session.
module tb_magic_ctl;

    localparam int          NTRIG   = 2;
    localparam int          NCFG    = 12;
    localparam logic [7:0]  PORT    = 8'hFF;
    localparam logic [15:0] ENTRY   = 16'h0066;
    localparam logic [15:0] EXITA   = 16'hF000;
    localparam logic [15:0] REENT   = 16'hF008;
    localparam logic [7:0]  SIG     = 8'hEB;

    logic              clk28 = 1'b0;
    logic              rst_n = 1'b0;
    logic              mreq = 1'b0, ioreq = 1'b0, m1 = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [15:0]       a = 16'h0000;
    logic [7:0]        d = 8'h00;
    logic              n_int = 1'b1, n_int_next = 1'b1;
    logic [NTRIG-1:0]  trig = '0;
    logic              n_nmi, magic_mode, magic_map, rd_oe;
    logic [2:0]        cause;
    logic [NCFG*8-1:0] cfg;
    logic [NCFG-1:0]   cfg_wstb;
    logic [7:0]        rd_data;

    magic_ctl #(.NTRIG(NTRIG), .NCFG(NCFG)) dut (
        .clk28(clk28), .rst_n(rst_n), .mreq(mreq), .ioreq(ioreq), .m1(m1),
        .rd(rd), .wr(wr), .a(a), .d(d), .n_int(n_int), .n_int_next(n_int_next),
        .trig(trig), .n_nmi(n_nmi), .magic_mode(magic_mode), .magic_map(magic_map),
        .cause(cause), .cfg(cfg), .cfg_wstb(cfg_wstb), .rd_oe(rd_oe), .rd_data(rd_data)
    );

    always #5 clk28 = ~clk28;

    int n_vec = 0;
    int n_err = 0;

    // Model: observable session status at transaction boundaries.
    bit         m_mode, m_map, m_nmi, boot_pending, reenter_wait;
    logic [2:0] m_cause;
    logic [7:0] m_cfg [NCFG];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NCFG*8-1:0] exp_cfg();
        logic [NCFG*8-1:0] v;
        for (int i = 0; i < NCFG; i++) v[8*i +: 8] = m_cfg[i];
        return v;
    endfunction

    task automatic step();
        @(posedge clk28);
        #1;
    endtask

    task automatic bus_idle();
        mreq = 0; ioreq = 0; m1 = 0; rd = 0; wr = 0;
        n_int = 1; n_int_next = 1; trig = '0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".nmi"},   128'(n_nmi),      128'(m_nmi));
        chk({tag, ".mode"},  128'(magic_mode), 128'(m_mode));
        chk({tag, ".map"},   128'(magic_map),  128'(m_map));
        chk({tag, ".cause"}, 128'(cause),      128'(m_cause));
        chk({tag, ".cfg"},   128'(cfg),        128'(exp_cfg()));
    endtask

    task automatic do_reset();
        bus_idle();
        rst_n = 0;
        step(); step();
        m_mode = 1; m_map = 1; m_nmi = 1; m_cause = 0;
        boot_pending = 1; reenter_wait = 0;
        for (int i = 0; i < NCFG; i++) m_cfg[i] = 8'h00;
        chk_all("rst");
        chk("rst.wstb", 128'(cfg_wstb), 128'(0));
        chk("rst.oe",   128'(rd_oe),    128'(0));
        chk("rst.data", 128'(rd_data),  128'(0));
        rst_n = 1;
        step();
        chk_all("rst_rel");
    endtask

    // INT sample with given levels and trigger vector.
    task automatic int_pulse(input logic ni, input logic nn, input logic [NTRIG-1:0] t);
        if (ni && !nn && !boot_pending && !m_mode && t != '0) begin
            m_nmi = 0; m_mode = 1;
            for (int i = NTRIG - 1; i >= 0; i--) if (t[i]) m_cause = 3'(i);
        end
        n_int = ni; n_int_next = nn; trig = t;
        step();
        chk_all("int");
        bus_idle();
    endtask

    // Memory read held two cycles, then one idle cycle. Optional INT edge
    // with all triggers set on the first cycle.
    task automatic mem_rd(input logic [15:0] ad, input logic [7:0] dat, input logic ism1,
                          input logic wtrig);
        bit mid_mode, mid_map, mid_nmi;
        mid_mode = m_mode; mid_map = m_map; mid_nmi = m_nmi;
        if (boot_pending) begin
            if (ism1) begin
                boot_pending = 0;
                if (dat != SIG) begin m_mode = 0; m_map = 0; end
            end
        end else if (!m_nmi) begin
            if (ism1 && ad == ENTRY) begin
                mid_nmi = 1; mid_map = 1; m_nmi = 1; m_map = 1;
                if (dat != SIG) begin m_mode = 0; m_map = 0; end
            end
        end else if (reenter_wait) begin
            if (ism1) begin mid_map = 1; m_map = 1; reenter_wait = 0; end
        end else if (m_mode && m_map) begin
            if (ad == EXITA) begin
                mid_mode = 0; m_mode = 0; m_map = 0;
            end else if (ad == REENT) begin
                m_map = 0; reenter_wait = 1;
            end
        end
        mreq = 1; rd = 1; m1 = ism1; a = ad; d = dat;
        if (wtrig) begin n_int = 1; n_int_next = 0; trig = '1; end
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rd.mid.nmi",  128'(n_nmi),      128'(mid_nmi));
            chk("rd.mid.mode", 128'(magic_mode), 128'(mid_mode));
            chk("rd.mid.map",  128'(magic_map),  128'(mid_map));
            n_int_next = 1; trig = '0;
        end
        bus_idle();
        step();
        chk_all("rd");
    endtask

    task automatic io_wr(input logic [15:0] ad, input logic [7:0] dat);
        logic [NCFG-1:0] ws;
        int ix;
        ws = '0;
        ix = int'(ad[15:8]);
        if (m_map && ad[7:0] == PORT && ix < NCFG) begin
            m_cfg[ix] = dat;
            ws[ix] = 1'b1;
        end
        ioreq = 1; wr = 1; a = ad; d = dat;
        step();
        chk("wr.wstb", 128'(cfg_wstb), 128'(ws));
        step();
        chk("wr.wstb_once", 128'(cfg_wstb), 128'(0));
        bus_idle();
        step();
        chk_all("wr");
    endtask

    task automatic io_rd(input logic [15:0] ad);
        logic       eoe;
        logic [7:0] edat;
        int         ix;
        ix   = int'(ad[15:8]);
        eoe  = 0;
        edat = 8'h00;
        if (m_map && ad[7:0] == PORT) begin
            if (ix < NCFG)       begin eoe = 1; edat = m_cfg[ix]; end
            else if (ix == 255)  begin eoe = 1; edat = {m_mode, 4'b0000, m_cause}; end
        end
        ioreq = 1; rd = 1; a = ad;
        step();
        chk("rd_oe", 128'(rd_oe), 128'(eoe));
        if (eoe) chk("rd_data", 128'(rd_data), 128'(edat));
        step();
        bus_idle();
        step();
        chk("rd_oe.drop", 128'(rd_oe), 128'(0));
    endtask

    initial begin
        logic [15:0] ad;
        logic [7:0]  dat;
        int          r;

        // Boot with good and bad signature.
        do_reset();
        mem_rd(16'h0010, 8'h3E, 0, 0);   // non-M1 read does not count
        mem_rd(16'h0000, SIG, 1, 0);
        do_reset();
        mem_rd(16'h0000, 8'h00, 1, 0);

        // Trigger arbitration and NMI entry.
        int_pulse(1, 0, 2'b11);
        mem_rd(ENTRY, SIG, 1, 0);
        int_pulse(1, 0, 2'b10);          // ignored while mode=1

        // Config bank access.
        io_wr(16'h03FF, 8'h5A);
        io_rd(16'h03FF);
        io_rd(16'hFFFF);
        io_rd(16'h0EFF);                  // beyond bank
        io_wr(16'h0CFF, 8'h77);           // ignored index

        // Re-enter and exit (with a simultaneous trigger on exit).
        mem_rd(REENT, 8'h00, 0, 0);
        mem_rd(16'h1234, 8'h00, 1, 0);
        mem_rd(EXITA, 8'h00, 0, 1);
        io_wr(16'h03FF, 8'hA5);
        io_rd(16'h03FF);

        // Second trigger source, bad signature on entry.
        int_pulse(1, 0, 2'b10);
        mem_rd(ENTRY, 8'h00, 1, 0);

        // Reset mid-session.
        int_pulse(1, 0, 2'b01);
        do_reset();
        mem_rd(16'h0000, SIG, 1, 0);

        // Randomized transactions.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                do_reset();
            end else if (r < 21) begin
                if ($urandom_range(0, 9) < 7) int_pulse(1, 0, 2'($urandom_range(0, 3)));
                else int_pulse(1'($urandom_range(0, 1)), 1, 2'($urandom_range(0, 3)));
            end else if (r < 56) begin
                case ($urandom_range(0, 4))
                    0, 1:    ad = ENTRY;
                    2:       ad = EXITA;
                    3:       ad = REENT;
                    default: ad = 16'($urandom_range(0, 16'h7FFF));
                endcase
                if (reenter_wait && (ad == EXITA || ad == REENT)) ad = 16'h1234;
                dat = ($urandom_range(0, 9) < 8) ? SIG : 8'($urandom_range(0, 255));
                mem_rd(ad, dat, ($urandom_range(0, 9) < 7), 0);
            end else if (r < 96) begin
                ad[15:8] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
                ad[7:0]  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : PORT;
                if (r < 76) io_wr(ad, 8'($urandom_range(0, 255)));
                else        io_rd(ad);
            end else begin
                bus_idle();
                step();
                chk_all("idle");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
